// File: rtl/rst_seq_ctrl.sv
// Staged reset-release sequencer: holds all stages in reset, then releases them
// one at a time in index order, waiting for each stage ack with a timeout.
module rst_seq_ctrl #(
    parameter int unsigned         N_STAGE     = 4,
    parameter int unsigned         MIN_ASSERT  = 16,
    parameter int unsigned         GAP_CYCLES  = 1000,
    parameter int unsigned         ACK_TIMEOUT = 100_000_000,
    parameter logic [N_STAGE-1:0]  ACK_MASK    = '1
) (
    input  logic               clk_i,
    input  logic               arst_n_i,
    input  logic               sw_rst_n_i,
    input  logic [N_STAGE-1:0] stage_ack_i,
    output logic [N_STAGE-1:0] stage_rst_n_o,
    output logic               all_done_o,
    output logic               fault_o,
    output logic [3:0]         fault_stage_o,
    output logic [2:0]         state_o
);

    localparam int unsigned KW = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;

    typedef enum logic [2:0] {
        ST_ASSERT   = 3'd0,
        ST_GAP      = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_DONE     = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [31:0]        cnt, cnt_nxt;
    logic [KW-1:0]      k, k_nxt;
    logic               sw_meta, sw_s;
    logic [N_STAGE-1:0] ack_meta, ack_s;
    logic [N_STAGE-1:0] rst_n_nxt;
    logic               done_nxt, fault_nxt;
    logic [3:0]         fault_stage_nxt;

    logic rst_req, release_now, accept, timeout, last;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sw_meta  <= 1'b0;
            sw_s     <= 1'b0;
            ack_meta <= '0;
            ack_s    <= '0;
        end else begin
            sw_meta  <= sw_rst_n_i;
            sw_s     <= sw_meta;
            ack_meta <= stage_ack_i;
            ack_s    <= ack_meta;
        end
    end

    // A reset request overrides every other event on the same cycle.
    assign rst_req     = (state != ST_ASSERT) && !sw_s;
    assign last        = (k == KW'(N_STAGE - 1));
    assign release_now = !rst_req && (state == ST_GAP) && (cnt == 32'(GAP_CYCLES - 1));
    assign accept      = !rst_req && (((state == ST_WAIT_ACK) && ack_s[k]) ||
                                      (release_now && !ACK_MASK[k]));
    assign timeout     = !rst_req && (state == ST_WAIT_ACK) && !ack_s[k] &&
                         (cnt == 32'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state         <= ST_ASSERT;
            cnt           <= '0;
            k             <= '0;
            stage_rst_n_o <= '0;
            all_done_o    <= 1'b0;
            fault_o       <= 1'b0;
            fault_stage_o <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            k             <= k_nxt;
            stage_rst_n_o <= rst_n_nxt;
            all_done_o    <= done_nxt;
            fault_o       <= fault_nxt;
            fault_stage_o <= fault_stage_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        k_nxt     = k;
        if (rst_req) begin
            state_nxt = ST_ASSERT;
            cnt_nxt   = '0;
            k_nxt     = '0;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (!sw_s) begin
                        cnt_nxt = '0;
                    end else if (cnt == 32'(MIN_ASSERT - 1)) begin
                        state_nxt = ST_GAP;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end
                ST_GAP: begin
                    if (release_now) begin
                        cnt_nxt = '0;
                        if (accept) begin
                            if (last) begin
                                state_nxt = ST_DONE;
                            end else begin
                                k_nxt = k + KW'(1);
                            end
                        end else begin
                            state_nxt = ST_WAIT_ACK;
                        end
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end
                ST_WAIT_ACK: begin
                    if (accept) begin
                        cnt_nxt = '0;
                        if (last) begin
                            state_nxt = ST_DONE;
                        end else begin
                            state_nxt = ST_GAP;
                            k_nxt     = k + KW'(1);
                        end
                    end else if (timeout) begin
                        state_nxt = ST_FAULT;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end
                default: cnt_nxt = '0;
            endcase
        end
    end

    always_comb begin
        rst_n_nxt       = stage_rst_n_o;
        done_nxt        = all_done_o;
        fault_nxt       = fault_o;
        fault_stage_nxt = fault_stage_o;
        if (rst_req) begin
            rst_n_nxt       = '0;
            done_nxt        = 1'b0;
            fault_nxt       = 1'b0;
            fault_stage_nxt = '0;
        end else begin
            if (release_now) begin
                rst_n_nxt[k] = 1'b1;
            end
            if (accept && last) begin
                done_nxt = 1'b1;
            end
            if (timeout) begin
                fault_nxt       = 1'b1;
                fault_stage_nxt = 4'(k);
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: edge-counted release timing, timeout, ack race,
// sw reset requests, masked stage and async reset.
module tb_rst_seq_ctrl;

    logic       clk;
    logic       arst_n;
    logic       sw_rst_n;
    logic [2:0] ack;
    logic [2:0] ack_m;
    logic [2:0] rst_n;
    logic       done;
    logic       fault;
    logic [3:0] fault_stage;
    logic [2:0] state;
    logic [2:0] rst_n_m;
    logic       done_m;
    logic       fault_m;
    logic [3:0] fault_stage_m;
    logic [2:0] state_m;

    int checks   = 0;
    int failures = 0;

    rst_seq_ctrl #(
        .N_STAGE    (3),
        .MIN_ASSERT (8),
        .GAP_CYCLES (4),
        .ACK_TIMEOUT(20),
        .ACK_MASK   (3'b111)
    ) u_dut (
        .clk_i        (clk),
        .arst_n_i     (arst_n),
        .sw_rst_n_i   (sw_rst_n),
        .stage_ack_i  (ack),
        .stage_rst_n_o(rst_n),
        .all_done_o   (done),
        .fault_o      (fault),
        .fault_stage_o(fault_stage),
        .state_o      (state)
    );

    rst_seq_ctrl #(
        .N_STAGE    (3),
        .MIN_ASSERT (8),
        .GAP_CYCLES (4),
        .ACK_TIMEOUT(20),
        .ACK_MASK   (3'b101)
    ) u_dut_mask (
        .clk_i        (clk),
        .arst_n_i     (arst_n),
        .sw_rst_n_i   (sw_rst_n),
        .stage_ack_i  (ack_m),
        .stage_rst_n_o(rst_n_m),
        .all_done_o   (done_m),
        .fault_o      (fault_m),
        .fault_stage_o(fault_stage_m),
        .state_o      (state_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle sw request; returns sampled after the edge that applies it (edge 3).
    task automatic sw_pulse(input logic [2:0] exp_before);
        sw_rst_n = 1'b0;
        tick(1);
        sw_rst_n = 1'b1;
        tick(1);
        chk_val("pulse_lat2_rst", 32'(rst_n), 32'(exp_before));
        tick(1);
        chk_val("pulse_lat3_rst", 32'(rst_n), 32'h0);
        chk_val("pulse_lat3_state", 32'(state), 32'd0);
        chk_val("pulse_lat3_done", 32'(done), 32'd0);
        chk_val("pulse_lat3_fault", 32'(fault), 32'd0);
    endtask

    initial begin
        arst_n   = 1'b0;
        sw_rst_n = 1'b1;
        ack      = 3'b111;
        ack_m    = 3'b101;
        tick(3);
        chk_val("rst_stage", 32'(rst_n), 32'h0);
        chk_val("rst_done", 32'(done), 32'h0);
        chk_val("rst_fault", 32'(fault), 32'h0);
        chk_val("rst_fstage", 32'(fault_stage), 32'h0);
        chk_val("rst_state", 32'(state), 32'h0);

        // Normal sequence: edges counted from arst release.
        arst_n = 1'b1;
        tick(13);
        chk_val("a_e13_rst", 32'(rst_n), 32'b000);
        tick(1);
        chk_val("a_e14_rst", 32'(rst_n), 32'b001);
        chk_val("a_e14_state", 32'(state), 32'd2);
        tick(4);
        chk_val("a_e18_rst", 32'(rst_n), 32'b001);
        tick(1);
        chk_val("a_e19_rst", 32'(rst_n), 32'b011);
        chk_val("m_e19_rst", 32'(rst_n_m), 32'b011);
        chk_val("m_e19_state", 32'(state_m), 32'd1);
        tick(4);
        chk_val("m_e23_rst", 32'(rst_n_m), 32'b111);
        chk_val("m_e23_done", 32'(done_m), 32'd0);
        tick(1);
        chk_val("a_e24_rst", 32'(rst_n), 32'b111);
        chk_val("a_e24_done", 32'(done), 32'd0);
        chk_val("m_e24_done", 32'(done_m), 32'd1);
        chk_val("m_e24_fault", 32'(fault_m), 32'd0);
        chk_val("m_e24_state", 32'(state_m), 32'd3);
        tick(1);
        chk_val("a_e25_done", 32'(done), 32'd1);
        chk_val("a_e25_state", 32'(state), 32'd3);
        chk_val("a_e25_fault", 32'(fault), 32'd0);

        // Replay after a one-cycle sw pulse in DONE.
        sw_pulse(3'b111);
        tick(11);
        chk_val("b_e14_rst", 32'(rst_n), 32'b000);
        tick(1);
        chk_val("b_e15_rst", 32'(rst_n), 32'b001);
        tick(11);
        chk_val("b_e26_done", 32'(done), 32'd1);
        chk_val("b_e26_rst", 32'(rst_n), 32'b111);

        // Stage 1 never acks: timeout on the 20th WAIT_ACK edge.
        ack = 3'b101;
        sw_pulse(3'b111);
        tick(36);
        chk_val("c_e39_fault", 32'(fault), 32'd0);
        chk_val("c_e39_state", 32'(state), 32'd2);
        tick(1);
        chk_val("c_e40_fault", 32'(fault), 32'd1);
        chk_val("c_e40_fstage", 32'(fault_stage), 32'd1);
        chk_val("c_e40_rst", 32'(rst_n), 32'b011);
        chk_val("c_e40_state", 32'(state), 32'd4);
        tick(100);
        chk_val("c_hold_fault", 32'(fault), 32'd1);
        chk_val("c_hold_fstage", 32'(fault_stage), 32'd1);
        chk_val("c_hold_rst", 32'(rst_n), 32'b011);
        chk_val("c_hold_state", 32'(state), 32'd4);
        chk_val("c_hold_done", 32'(done), 32'd0);

        // Ack reaches the FSM exactly on the timeout edge: ack wins.
        sw_pulse(3'b011);
        tick(34);
        ack = 3'b111;
        tick(2);
        chk_val("d_e39_state", 32'(state), 32'd2);
        tick(1);
        chk_val("d_e40_fault", 32'(fault), 32'd0);
        chk_val("d_e40_state", 32'(state), 32'd1);
        chk_val("d_e40_rst", 32'(rst_n), 32'b011);
        tick(5);
        chk_val("d_e45_done", 32'(done), 32'd1);
        chk_val("d_e45_rst", 32'(rst_n), 32'b111);
        chk_val("d_e45_fault", 32'(fault), 32'd0);

        // sw held low for 50 cycles during the GAP before stage 2.
        sw_pulse(3'b111);
        tick(18);
        sw_rst_n = 1'b0;
        tick(2);
        chk_val("e_e23_rst", 32'(rst_n), 32'b011);
        chk_val("e_e23_state", 32'(state), 32'd1);
        tick(1);
        chk_val("e_e24_rst", 32'(rst_n), 32'b000);
        chk_val("e_e24_state", 32'(state), 32'd0);
        tick(40);
        chk_val("e_low_rst", 32'(rst_n), 32'b000);
        chk_val("e_low_state", 32'(state), 32'd0);
        tick(7);
        sw_rst_n = 1'b1;
        ack      = 3'b000;
        tick(13);
        chk_val("e_r12_rst", 32'(rst_n), 32'b000);
        chk_val("e_r12_state", 32'(state), 32'd1);
        tick(1);
        chk_val("e_r13_rst", 32'(rst_n), 32'b001);
        chk_val("e_r13_state", 32'(state), 32'd2);

        // Async reset in the middle of WAIT_ACK.
        tick(3);
        chk_val("f_wait_state", 32'(state), 32'd2);
        #2;
        arst_n = 1'b0;
        #1;
        chk_val("f_arst_rst", 32'(rst_n), 32'b000);
        chk_val("f_arst_state", 32'(state), 32'd0);
        chk_val("f_arst_done", 32'(done), 32'd0);
        chk_val("f_arst_fault", 32'(fault), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
